// File: rtl/pp_lr_fill.sv
// Left-right consistency check with last-good fill on the reversed-line disparity stream.
// Two clken-qualified register stages: check + line position, then fill selection.
module pp_lr_fill #(
  parameter int DWIDTH       = 22,
  parameter int LR_THRESH    = 1,
  parameter int FILL_DEFAULT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clken,
  input  logic              enable,
  input  logic [10:0]       width,
  input  logic              din_valid,
  input  logic [DWIDTH-1:0] din,
  output logic [10:0]       dout,
  output logic              dout_valid,
  output logic              hole,
  output logic              line_done
);

  localparam int PW = 11;
  localparam logic [PW:0]   THRESH = (PW+1)'(LR_THRESH);
  localparam logic [PW-1:0] FILL   = PW'(FILL_DEFAULT);

  logic          acc;
  logic [PW-1:0] pri, chk, last_idx;
  logic [PW:0]   diff;

  logic [PW-1:0] pix_cnt;
  logic          s1_v, s1_ok, s1_last;
  logic [PW-1:0] s1_d;

  logic          seen;
  logic [PW-1:0] last_good;

  assign acc      = clken && enable && din_valid;
  assign pri      = din[2*PW-1:PW];
  assign chk      = din[PW-1:0];
  assign last_idx = width - 11'd1;

  // Magnitude of the difference in 12 bits so 0 vs 2047 cannot wrap to a small value.
  assign diff = (pri >= chk) ? ({1'b0, pri} - {1'b0, chk})
                             : ({1'b0, chk} - {1'b0, pri});

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours regardless of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_cnt <= '0;
      s1_v    <= 1'b0;
      s1_d    <= '0;
      s1_ok   <= 1'b0;
      s1_last <= 1'b0;
    end else if (clken) begin
      s1_v    <= acc;
      s1_d    <= pri;
      s1_ok   <= (diff <= THRESH);
      s1_last <= (pix_cnt == last_idx);
      if (acc) begin
        pix_cnt <= (pix_cnt == last_idx) ? '0 : pix_cnt + 11'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      hole       <= 1'b0;
      line_done  <= 1'b0;
      seen       <= 1'b0;
      last_good  <= '0;
    end else if (clken) begin
      dout_valid <= s1_v;
      line_done  <= s1_v && s1_last;
      if (s1_v) begin
        if (s1_ok) begin
          dout      <= s1_d;
          hole      <= 1'b0;
          last_good <= s1_d;
          seen      <= 1'b1;
        end else begin
          dout <= seen ? last_good : FILL;
          hole <= 1'b1;
        end
        // NOTE: the later assignment wins, so a line end clears seen even
        // when the same pixel was consistent and tried to set it.
        if (s1_last) begin
          seen <= 1'b0;
        end
      end
    end
  end

endmodule
